// File: rtl/video_timing_pkg.sv
// Shared timing presets and helpers for the raster timing generator.
// Mode constants are grouped per standard so a top-level can pick them by name.
package video_timing_pkg;

  // VGA 640x480 @ 25.175 MHz, negative syncs
  localparam int VGA_H_ACT   = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_V_ACT   = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;
  localparam bit VGA_HS_POL  = 1'b0;
  localparam bit VGA_VS_POL  = 1'b0;

  // SVGA 800x600 @ 40 MHz, positive syncs
  localparam int SVGA_H_ACT   = 800;
  localparam int SVGA_H_FRONT = 40;
  localparam int SVGA_H_SYNC  = 128;
  localparam int SVGA_H_BACK  = 88;
  localparam int SVGA_V_ACT   = 600;
  localparam int SVGA_V_FRONT = 1;
  localparam int SVGA_V_SYNC  = 4;
  localparam int SVGA_V_BACK  = 23;
  localparam bit SVGA_HS_POL  = 1'b1;
  localparam bit SVGA_VS_POL  = 1'b1;

  // Game Boy LCD source window
  localparam int GB_WIN_W = 160;
  localparam int GB_WIN_H = 144;

  function automatic int timing_total(input int front, input int sync,
                                      input int back, input int act);
    return front + sync + back + act;
  endfunction

endpackage

// File: rtl/scale_axis_counter.sv
// One axis of the integer-scaled window: source index and phase within a source
// pixel, tracked incrementally and restarted whenever the position hits start_i.
module scale_axis_counter #(
  parameter int CW    = 11,
  parameter int SCALE = 3,
  parameter int LEN   = 160
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] pos_i,
  input  logic [CW-1:0] start_i,
  output logic [7:0]    src_o,
  output logic          phase0_o,
  output logic          in_range_o
);

  localparam logic [2:0]    PHASE_LAST = 3'(SCALE - 1);
  localparam logic [CW-1:0] SPAN       = CW'(LEN * SCALE);

  logic [2:0] phase_q, phase_d, phase_cur;
  logic [7:0] src_q, src_d, src_cur;
  logic       at_start;

  // The stored state describes the current position unless we are at the window
  // edge, which forces a clean restart regardless of what was stored.
  assign at_start  = (pos_i == start_i);
  assign phase_cur = at_start ? 3'd0 : phase_q;
  assign src_cur   = at_start ? 8'd0 : src_q;

  always_comb begin
    phase_d = phase_q;
    src_d   = src_q;
    if (clr_i) begin
      phase_d = 3'd0;
      src_d   = 8'd0;
    end else if (en_i) begin
      if (phase_cur == PHASE_LAST) begin
        phase_d = 3'd0;
        src_d   = src_cur + 8'd1;
      end else begin
        phase_d = phase_cur + 3'd1;
        src_d   = src_cur;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 3'd0;
      src_q   <= 8'd0;
    end else begin
      phase_q <= phase_d;
      src_q   <= src_d;
    end
  end

  assign src_o      = src_cur;
  assign phase0_o   = (phase_cur == 3'd0);
  assign in_range_o = (pos_i >= start_i) && (pos_i < start_i + SPAN);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with genlock restart and a centred,
// integer-scaled source window. All outputs are registered decodes of h/v counters.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CW       = 11,
  parameter int H_ACT    = VGA_H_ACT,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACT    = VGA_V_ACT,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter bit HS_POL   = VGA_HS_POL,
  parameter bit VS_POL   = VGA_VS_POL,
  parameter int WIN_W    = GB_WIN_W,
  parameter int WIN_H    = GB_WIN_H,
  parameter int SCALE    = 3,
  parameter int WIN_X0   = 80,
  parameter int WIN_Y0   = 24,
  parameter int DE_DELAY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_sync,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          de_dly,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          win_en,
  output logic [7:0]    win_x,
  output logic [7:0]    win_y,
  output logic          win_grid,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = timing_total(H_FRONT, H_SYNC, H_BACK, H_ACT);
  localparam int V_TOTAL = timing_total(V_FRONT, V_SYNC, V_BACK, V_ACT);

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_ON  = CW'(H_FRONT);
  localparam logic [CW-1:0] H_SYNC_OFF = CW'(H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_ON  = CW'(V_FRONT);
  localparam logic [CW-1:0] V_SYNC_OFF = CW'(V_FRONT + V_SYNC);
  localparam logic [CW-1:0] H_BLANK    = CW'(H_TOTAL - H_ACT);
  localparam logic [CW-1:0] V_BLANK    = CW'(V_TOTAL - V_ACT);
  localparam logic [1:0][CW-1:0] AXIS_START = {CW'(WIN_Y0), CW'(WIN_X0)};

  generate
    if (WIN_W > 256 || WIN_H > 256 || SCALE < 1 || SCALE > 7 ||
        DE_DELAY < 0 || DE_DELAY > 7 ||
        WIN_X0 < 0 || WIN_Y0 < 0 ||
        WIN_X0 + WIN_W * SCALE > H_ACT || WIN_Y0 + WIN_H * SCALE > V_ACT ||
        H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_param_err
      $error("video_timing_gen: window does not fit the active area or parameters out of range");
    end
  endgenerate

  logic [CW-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (frame_sync) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  logic          h_act, v_act;
  logic [CW-1:0] x_c, y_c;

  assign h_act = (h_q >= H_BLANK);
  assign v_act = (v_q >= V_BLANK);
  assign x_c   = (h_act && v_act) ? h_q - H_BLANK : '0;
  assign y_c   = v_act ? v_q - V_BLANK : '0;

  // Axis 0 is X (steps every active pixel), axis 1 is Y (steps once per active line).
  logic [1:0][CW-1:0] axis_pos;
  logic [1:0][7:0]    axis_src;
  logic [1:0]         axis_en, axis_ph0, axis_in;

  assign axis_pos = {y_c, x_c};
  assign axis_en  = {v_act && (h_q == H_LAST), h_act};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      scale_axis_counter #(
        .CW   (CW),
        .SCALE(SCALE),
        .LEN  (gi == 0 ? WIN_W : WIN_H)
      ) u_axis (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (frame_sync),
        .en_i      (axis_en[gi]),
        .pos_i     (axis_pos[gi]),
        .start_i   (AXIS_START[gi]),
        .src_o     (axis_src[gi]),
        .phase0_o  (axis_ph0[gi]),
        .in_range_o(axis_in[gi])
      );
    end
  endgenerate

  logic          hs_d, vs_d, de_d, win_en_d, win_grid_d, line_start_d, frame_start_d;
  logic [CW-1:0] x_d, y_d;
  logic [7:0]    win_x_d, win_y_d;

  always_comb begin
    hs_d          = (h_q >= H_SYNC_ON && h_q < H_SYNC_OFF) ? HS_POL : ~HS_POL;
    vs_d          = (v_q >= V_SYNC_ON && v_q < V_SYNC_OFF) ? VS_POL : ~VS_POL;
    de_d          = h_act && v_act;
    x_d           = x_c;
    y_d           = y_c;
    win_en_d      = de_d && axis_in[0] && axis_in[1];
    win_x_d       = win_en_d ? axis_src[0] : 8'd0;
    win_y_d       = (v_act && axis_in[1]) ? axis_src[1] : 8'd0;
    win_grid_d    = win_en_d && (axis_ph0[0] || axis_ph0[1]);
    // While frame_sync holds the counters at zero the pulses stay quiet; they
    // fire on the first cycle that actually decodes the restarted raster.
    line_start_d  = (h_q == '0) && !frame_sync;
    frame_start_d = line_start_d && (v_q == '0);
  end

  logic          hs_q, vs_q, win_en_q, win_grid_q, line_start_q, frame_start_q;
  logic [CW-1:0] x_q, y_q;
  logic [7:0]    win_x_q, win_y_q;
  logic [DE_DELAY:0] de_sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_sr_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      win_en_q      <= 1'b0;
      win_x_q       <= 8'd0;
      win_y_q       <= 8'd0;
      win_grid_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_sr_q[0]    <= de_d;
      for (int i = 1; i <= DE_DELAY; i++) begin
        de_sr_q[i] <= de_sr_q[i-1];
      end
      x_q           <= x_d;
      y_q           <= y_d;
      win_en_q      <= win_en_d;
      win_x_q       <= win_x_d;
      win_y_q       <= win_y_d;
      win_grid_q    <= win_grid_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_sr_q[0];
  assign de_dly      = de_sr_q[DE_DELAY];
  assign x           = x_q;
  assign y           = y_q;
  assign win_en      = win_en_q;
  assign win_x       = win_x_q;
  assign win_y       = win_y_q;
  assign win_grid    = win_grid_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: two instances (negative and positive
// syncs, scale 3 and 2) in small raster modes, checked cycle by cycle against an arithmetic model.
module tb_video_timing_gen;

  localparam int HF [2] = '{3, 2};
  localparam int HSW[2] = '{5, 3};
  localparam int HBK[2] = '{4, 3};
  localparam int HA [2] = '{48, 40};
  localparam int VF [2] = '{2, 1};
  localparam int VSW[2] = '{2, 1};
  localparam int VBK[2] = '{3, 2};
  localparam int VA [2] = '{30, 20};
  localparam bit HP [2] = '{1'b0, 1'b1};
  localparam bit VP [2] = '{1'b0, 1'b1};
  localparam int WW [2] = '{13, 12};
  localparam int WH [2] = '{8, 8};
  localparam int SC [2] = '{3, 2};
  localparam int X0 [2] = '{5, 10};
  localparam int Y0 [2] = '{3, 4};
  localparam int DD [2] = '{2, 0};
  localparam int MAX_ERR = 25;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        de_dly;
    logic [10:0] x;
    logic [10:0] y;
    logic        win_en;
    logic [7:0]  win_x;
    logic [7:0]  win_y;
    logic        win_grid;
    logic        line_start;
    logic        frame_start;
  } obs_t;

  logic clk, rst, frame_sync;
  logic        hs_a, vs_a, de_a, dd_a, we_a, wg_a, ls_a, fs_a;
  logic [10:0] x_a, y_a;
  logic [7:0]  wx_a, wy_a;
  logic        hs_b, vs_b, de_b, dd_b, we_b, wg_b, ls_b, fs_b;
  logic [10:0] x_b, y_b;
  logic [7:0]  wx_b, wy_b;
  obs_t act0, act1;

  int   checks = 0;
  int   errors = 0;
  int   t_m[2];
  logic [7:0] dehist[2];
  obs_t exp_q0[$];
  obs_t exp_q1[$];

  video_timing_gen #(
    .CW(11), .H_ACT(HA[0]), .H_FRONT(HF[0]), .H_SYNC(HSW[0]), .H_BACK(HBK[0]),
    .V_ACT(VA[0]), .V_FRONT(VF[0]), .V_SYNC(VSW[0]), .V_BACK(VBK[0]),
    .HS_POL(HP[0]), .VS_POL(VP[0]), .WIN_W(WW[0]), .WIN_H(WH[0]), .SCALE(SC[0]),
    .WIN_X0(X0[0]), .WIN_Y0(Y0[0]), .DE_DELAY(DD[0])
  ) dut_a (
    .clk(clk), .rst(rst), .frame_sync(frame_sync),
    .hs(hs_a), .vs(vs_a), .de(de_a), .de_dly(dd_a), .x(x_a), .y(y_a),
    .win_en(we_a), .win_x(wx_a), .win_y(wy_a), .win_grid(wg_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  video_timing_gen #(
    .CW(11), .H_ACT(HA[1]), .H_FRONT(HF[1]), .H_SYNC(HSW[1]), .H_BACK(HBK[1]),
    .V_ACT(VA[1]), .V_FRONT(VF[1]), .V_SYNC(VSW[1]), .V_BACK(VBK[1]),
    .HS_POL(HP[1]), .VS_POL(VP[1]), .WIN_W(WW[1]), .WIN_H(WH[1]), .SCALE(SC[1]),
    .WIN_X0(X0[1]), .WIN_Y0(Y0[1]), .DE_DELAY(DD[1])
  ) dut_b (
    .clk(clk), .rst(rst), .frame_sync(frame_sync),
    .hs(hs_b), .vs(vs_b), .de(de_b), .de_dly(dd_b), .x(x_b), .y(y_b),
    .win_en(we_b), .win_x(wx_b), .win_y(wy_b), .win_grid(wg_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  assign act0 = {hs_a, vs_a, de_a, dd_a, x_a, y_a, we_a, wx_a, wy_a, wg_a, ls_a, fs_a};
  assign act1 = {hs_b, vs_b, de_b, dd_b, x_b, y_b, we_b, wx_b, wy_b, wg_b, ls_b, fs_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int h_tot(input int k);
    return HF[k] + HSW[k] + HBK[k] + HA[k];
  endfunction

  function automatic int v_tot(input int k);
    return VF[k] + VSW[k] + VBK[k] + VA[k];
  endfunction

  // Outputs expected after an edge at raster time t (pixels since frame start).
  function automatic obs_t model(input int k, input int t, input bit fs);
    obs_t o;
    int h, v, hb, vb, xv, yv;
    bit xin, yin;
    o  = '0;
    h  = t % h_tot(k);
    v  = (t / h_tot(k)) % v_tot(k);
    hb = h_tot(k) - HA[k];
    vb = v_tot(k) - VA[k];
    o.hs = (h >= HF[k] && h < HF[k] + HSW[k]) ? HP[k] : ~HP[k];
    o.vs = (v >= VF[k] && v < VF[k] + VSW[k]) ? VP[k] : ~VP[k];
    o.de = (h >= hb) && (v >= vb);
    xv   = o.de ? h - hb : 0;
    yv   = (v >= vb) ? v - vb : 0;
    o.x  = 11'(xv);
    o.y  = 11'(yv);
    xin  = o.de && xv >= X0[k] && xv < X0[k] + WW[k] * SC[k];
    yin  = (v >= vb) && yv >= Y0[k] && yv < Y0[k] + WH[k] * SC[k];
    o.win_en   = xin && yin;
    o.win_x    = o.win_en ? 8'((xv - X0[k]) / SC[k]) : 8'd0;
    o.win_y    = yin ? 8'((yv - Y0[k]) / SC[k]) : 8'd0;
    o.win_grid = o.win_en && (((xv - X0[k]) % SC[k]) == 0 || ((yv - Y0[k]) % SC[k]) == 0);
    o.line_start  = (h == 0) && !fs;
    o.frame_start = (h == 0) && (v == 0) && !fs;
    return o;
  endfunction

  function automatic obs_t reset_val(input int k);
    obs_t o;
    o    = '0;
    o.hs = ~HP[k];
    o.vs = ~VP[k];
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("hs=%b vs=%b de=%b de_dly=%b x=%0d y=%0d win_en=%b win_x=%0d win_y=%0d grid=%b ls=%b fs=%b",
                     o.hs, o.vs, o.de, o.de_dly, o.x, o.y, o.win_en, o.win_x, o.win_y,
                     o.win_grid, o.line_start, o.frame_start);
  endfunction

  task automatic check(input string name, input int k, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d @%0t actual: %s required: %s", name, k, $time, fmt(a), fmt(e));
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected at the next edge.
  task automatic drive(input bit r, input bit fs);
    obs_t o;
    @(negedge clk);
    rst        = r;
    frame_sync = fs;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        o         = reset_val(k);
        t_m[k]    = 0;
        dehist[k] = 8'd0;
      end else begin
        o         = model(k, t_m[k], fs);
        o.de_dly  = (DD[k] == 0) ? o.de : dehist[k][DD[k]-1];
        dehist[k] = {dehist[k][6:0], o.de};
        t_m[k]    = fs ? 0 : (t_m[k] + 1) % (h_tot(k) * v_tot(k));
      end
      if (k == 0) exp_q0.push_back(o);
      else        exp_q1.push_back(o);
    end
  endtask

  always @(posedge clk) begin
    obs_t e;
    #1;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      check("scoreboard", 0, act0, e);
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      check("scoreboard", 1, act1, e);
    end
  end

  initial begin
    int fs_hold;
    int target;
    bit fs;
    rst        = 1'b1;
    frame_sync = 1'b0;
    t_m[0] = 0; t_m[1] = 0;
    dehist[0] = 8'd0; dehist[1] = 8'd0;
    #1;
    check("reset_initial", 0, act0, reset_val(0));
    check("reset_initial", 1, act1, reset_val(1));
    repeat (3) drive(1'b1, 1'b0);

    $display("phase: free run, two frames of dut0");
    for (int n = 0; n < 2 * h_tot(0) * v_tot(0) + 20 && errors < MAX_ERR; n++)
      drive(1'b0, 1'b0);

    $display("phase: frame_sync at h=30 v=20 of dut0, then one frame");
    target = 20 * h_tot(0) + 30;
    for (int n = 0; n < h_tot(0) * v_tot(0) && t_m[0] != target && errors < MAX_ERR; n++)
      drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    for (int n = 0; n < h_tot(0) * v_tot(0) + 10 && errors < MAX_ERR; n++)
      drive(1'b0, 1'b0);

    $display("phase: random frame_sync pulses and holds");
    fs_hold = 0;
    for (int n = 0; n < 3000 && errors < MAX_ERR; n++) begin
      if (fs_hold > 0) begin
        fs = 1'b1;
        fs_hold--;
      end else if ($urandom_range(0, 149) == 0) begin
        fs = 1'b1;
        fs_hold = int'($urandom_range(0, 3));
      end else begin
        fs = 1'b0;
      end
      drive(1'b0, fs);
    end
    drive(1'b0, 1'b0);

    $display("phase: asynchronous reset in the middle of an active line");
    for (int n = 0; n < h_tot(0) * v_tot(0) && errors < MAX_ERR &&
         !((t_m[0] % h_tot(0)) >= h_tot(0) - HA[0] + 10 &&
           (t_m[0] / h_tot(0)) >= v_tot(0) - VA[0] + 5); n++)
      drive(1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("reset_async", 0, act0, reset_val(0));
    check("reset_async", 1, act1, reset_val(1));
    repeat (2) drive(1'b1, 1'b0);

    $display("phase: free run after reset release");
    for (int n = 0; n < h_tot(0) * v_tot(0) + 300 && errors < MAX_ERR; n++)
      drive(1'b0, 1'b0);

    @(negedge clk);
    frame_sync = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual: %0d/%0d entries left required: 0/0",
               exp_q0.size(), exp_q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
